// File: rtl/hilo_mdu_ctrl_if.sv
// rtl/hilo_mdu_ctrl_if.sv - issue/result bundle between EX operand network and the HI/LO sequencer
//
// Signals (slave = hilo_mdu_ctrl, master = upstream EX stage):
//   start   issue request, op op code, src_a/src_b rs/rt operands, cancel pipeline flush
//   stall   hold pipeline, busy sequencer not idle
//   hi_we/lo_we, hi_o/lo_o   HI/LO write port
interface hilo_mdu_ctrl_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        stall;
    logic        busy;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    modport master (
        output start, op, src_a, src_b, cancel,
        input  stall, busy, hi_we, lo_we, hi_o, lo_o
    );

    modport slave (
        input  start, op, src_a, src_b, cancel,
        output stall, busy, hi_we, lo_we, hi_o, lo_o
    );
endinterface

// File: rtl/hilo_mdu_ctrl.sv
// rtl/hilo_mdu_ctrl.sv - HI/LO sequencer: iterative mul/div, MTHI/MTLO, pipeline stall
//
// Ports:
//   clk   core clock, rising edge
//   rst   asynchronous active-low reset
//   bus   hilo_mdu_ctrl_if.slave (start/op/src_a/src_b/cancel in; stall/busy/hi_we/lo_we/hi_o/lo_o out)
// Optional macro HILO_FAST_MUL_EN: single-cycle combinational MULT/MULTU instead of 32 iterations.
module hilo_mdu_ctrl (
    input  logic                 clk,
    input  logic                 rst,
    hilo_mdu_ctrl_if.slave       bus
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [63:0] r_acc;      // MUL: {partial high, remaining multiplier bits}
    logic [31:0] r_mcand;
    logic [32:0] r_rem;      // DIV partial remainder
    logic [31:0] r_quo;      // DIV: dividend bits shifted out, quotient bits shifted in
    logic [31:0] r_divisor;
    logic        r_neg_q;    // negate product / quotient at the end
    logic        r_neg_r;    // negate remainder at the end
    logic        r_is_div;

    logic        w_signed;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic        w_idle_start;
    logic [32:0] w_mul_sum;
    logic [32:0] w_trial;
    logic [33:0] w_diff;
    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic        w_mthi;
    logic        w_mtlo;
    logic        w_done;

    assign w_signed     = (bus.op == 3'd0) || (bus.op == 3'd2);
    assign w_abs_a      = (w_signed && bus.src_a[31]) ? (~bus.src_a + 32'd1) : bus.src_a;
    assign w_abs_b      = (w_signed && bus.src_b[31]) ? (~bus.src_b + 32'd1) : bus.src_b;
    assign w_idle_start = (r_state == S_IDLE) && bus.start && !bus.cancel;

    // Shift-add step: add multiplicand into the high half when the current multiplier bit is set.
    assign w_mul_sum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_mcand} : 33'd0);

    // Restoring step: trial-subtract divisor from the shifted remainder; borrow keeps the old value.
    assign w_trial = {r_rem[31:0], r_quo[31]};
    assign w_diff  = {1'b0, w_trial} - {2'b00, r_divisor};

`ifdef HILO_FAST_MUL_EN
    logic [63:0] w_fast_prod;
    assign w_fast_prod = {{32{w_signed & bus.src_a[31]}}, bus.src_a} *
                         {{32{w_signed & bus.src_b[31]}}, bus.src_b};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 6'd0;
            r_acc     <= 64'd0;
            r_mcand   <= 32'd0;
            r_rem     <= 33'd0;
            r_quo     <= 32'd0;
            r_divisor <= 32'd0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_is_div  <= 1'b0;
        end else if (bus.cancel) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start && (bus.op == 3'd0 || bus.op == 3'd1)) begin
                        r_is_div <= 1'b0;
`ifdef HILO_FAST_MUL_EN
                        r_acc   <= w_fast_prod;
                        r_neg_q <= 1'b0;
                        r_state <= S_DONE;
`else
                        r_acc   <= {32'd0, w_abs_b};
                        r_mcand <= w_abs_a;
                        r_neg_q <= w_signed && (bus.src_a[31] ^ bus.src_b[31]);
                        r_cnt   <= 6'd0;
                        r_state <= S_MUL;
`endif
                    end else if (bus.start && (bus.op == 3'd2 || bus.op == 3'd3)) begin
                        r_is_div <= 1'b1;
                        if (bus.src_b == 32'd0) begin
                            r_quo   <= 32'hFFFF_FFFF;
                            r_rem   <= {1'b0, bus.src_a};
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            r_rem     <= 33'd0;
                            r_quo     <= w_abs_a;
                            r_divisor <= w_abs_b;
                            r_neg_q   <= w_signed && (bus.src_a[31] ^ bus.src_b[31]);
                            r_neg_r   <= w_signed && bus.src_a[31];
                            r_cnt     <= 6'd0;
                            r_state   <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    r_acc <= {w_mul_sum, r_acc[31:1]};
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'd31) r_state <= S_DONE;
                end
                S_DIV: begin
                    if (w_diff[33]) begin
                        r_rem <= w_trial;
                        r_quo <= {r_quo[30:0], 1'b0};
                    end else begin
                        r_rem <= w_diff[32:0];
                        r_quo <= {r_quo[30:0], 1'b1};
                    end
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'd31) r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_prod = r_neg_q ? (~r_acc + 64'd1) : r_acc;
    assign w_quo  = r_neg_q ? (~r_quo + 32'd1) : r_quo;
    assign w_rem  = r_neg_r ? (~r_rem[31:0] + 32'd1) : r_rem[31:0];

    // Outputs are forced low while reset is asserted, independent of the request inputs.
    assign w_mthi = rst && w_idle_start && (bus.op == 3'd4);
    assign w_mtlo = rst && w_idle_start && (bus.op == 3'd5);
    assign w_done = rst && (r_state == S_DONE) && !bus.cancel;

    assign bus.hi_we = w_done || w_mthi;
    assign bus.lo_we = w_done || w_mtlo;
    assign bus.hi_o  = w_done ? (r_is_div ? w_rem : w_prod[63:32]) :
                       w_mthi ? bus.src_a : 32'd0;
    assign bus.lo_o  = w_done ? (r_is_div ? w_quo : w_prod[31:0]) :
                       w_mtlo ? bus.src_a : 32'd0;
    assign bus.busy  = rst && (r_state != S_IDLE);
    assign bus.stall = rst && ((w_idle_start && !bus.op[2]) ||
                               (r_state == S_MUL) || (r_state == S_DIV));
endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// tb/tb_hilo_mdu_ctrl.sv - directed self-checking bench for hilo_mdu_ctrl
module tb_hilo_mdu_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   ncyc;
    logic saw_we;

    hilo_mdu_ctrl_if bus ();

    hilo_mdu_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef HILO_FAST_MUL_EN
    localparam int MUL_STALL = 1;
`else
    localparam int MUL_STALL = 33;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch at a negedge, hold start while stalled, return at the sample point of the DONE cycle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int n);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        #1;
        n = 0;
        while (bus.stall && n < 200) begin
            n++;
            @(negedge clk);
            #1;
        end
        bus.start = 1'b0;
        if (n >= 200) chk("stall_timeout", 64'(n), 64'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.start = 1'b0; bus.op = 3'd0; bus.src_a = 32'd0; bus.src_b = 32'd0; bus.cancel = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", bus.stall, 1'b0);
        chk("rst_busy",  bus.busy,  1'b0);
        chk("rst_hi_we", bus.hi_we, 1'b0);
        chk("rst_lo_we", bus.lo_we, 1'b0);
        chk("rst_hi_o",  bus.hi_o,  32'd0);
        chk("rst_lo_o",  bus.lo_o,  32'd0);
        @(negedge clk);
        rst = 1'b1;

        // MULT -3 * 5
        run_op(3'd0, 32'hFFFF_FFFD, 32'd5, ncyc);
        chk("mult_stall_cycles", 64'(ncyc), 64'(MUL_STALL));
        chk("mult_hi_we", bus.hi_we, 1'b1);
        chk("mult_lo_we", bus.lo_we, 1'b1);
        chk("mult_hi", bus.hi_o, 32'hFFFF_FFFF);
        chk("mult_lo", bus.lo_o, 32'hFFFF_FFF1);
        chk("done_busy", bus.busy, 1'b1);
        chk("done_stall", bus.stall, 1'b0);
        @(negedge clk); #1;
        chk("after_done_busy", bus.busy, 1'b0);
        chk("after_done_we", bus.hi_we, 1'b0);

        // MULTU large operands: FFFFFFFF * FFFFFFFF = FFFFFFFE_00000001
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ncyc);
        chk("multu_hi", bus.hi_o, 32'hFFFF_FFFE);
        chk("multu_lo", bus.lo_o, 32'h0000_0001);

        // DIVU 100/7 then DIV -7/2 back-to-back
        run_op(3'd3, 32'd100, 32'd7, ncyc);
        chk("divu_cycles", 64'(ncyc), 64'd33);
        chk("divu_lo", bus.lo_o, 32'h0000_000E);
        chk("divu_hi", bus.hi_o, 32'h0000_0002);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, ncyc);
        chk("div_b2b_cycles", 64'(ncyc), 64'd33);
        chk("div_lo", bus.lo_o, 32'hFFFF_FFFD);
        chk("div_hi", bus.hi_o, 32'hFFFF_FFFF);

        // Divide by zero
        run_op(3'd2, 32'h1234_5678, 32'd0, ncyc);
        chk("div0_cycles", 64'(ncyc), 64'd1);
        chk("div0_we", bus.lo_we, 1'b1);
        chk("div0_lo", bus.lo_o, 32'hFFFF_FFFF);
        chk("div0_hi", bus.hi_o, 32'h1234_5678);

        // MTHI in IDLE
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd4; bus.src_a = 32'hDEAD_BEEF;
        #1;
        chk("mthi_hi_we", bus.hi_we, 1'b1);
        chk("mthi_hi", bus.hi_o, 32'hDEAD_BEEF);
        chk("mthi_lo_we", bus.lo_we, 1'b0);
        chk("mthi_stall", bus.stall, 1'b0);
        bus.cancel = 1'b1;
        #1;
        chk("mthi_cancel_we", bus.hi_we, 1'b0);
        bus.op = 3'd0;
        #1;
        chk("cancel_start_stall", bus.stall, 1'b0);
        @(negedge clk);
        bus.start = 1'b0; bus.cancel = 1'b0;
        #1;
        chk("cancel_start_busy", bus.busy, 1'b0);

        // MULTU then cancel at iteration 10; MTLO ignored while busy
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd1; bus.src_a = 32'd1234; bus.src_b = 32'd5678;
        saw_we = 1'b0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk); #1;
            saw_we = saw_we | bus.hi_we | bus.lo_we;
        end
`ifndef HILO_FAST_MUL_EN
        bus.op = 3'd5; bus.src_a = 32'h5555_AAAA;
        #1;
        chk("mtlo_busy_busy", bus.busy, 1'b1);
        chk("mtlo_busy_lo_we", bus.lo_we, 1'b0);
`endif
        bus.start = 1'b0; bus.cancel = 1'b1;
        #1;
        saw_we = saw_we | bus.hi_we | bus.lo_we;
        @(negedge clk);
        bus.cancel = 1'b0;
        #1;
        saw_we = saw_we | bus.hi_we | bus.lo_we;
        chk("cancel_idle_busy", bus.busy, 1'b0);
        chk("cancel_idle_stall", bus.stall, 1'b0);
        chk("cancel_no_write", saw_we, 1'b0);
        run_op(3'd3, 32'd9, 32'd3, ncyc);
        chk("divu93_lo", bus.lo_o, 32'd3);
        chk("divu93_hi", bus.hi_o, 32'd0);

        // Reset during DIV iteration 20
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd2; bus.src_a = 32'd1000; bus.src_b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        chk("pre_rst_busy", bus.busy, 1'b1);
        rst = 1'b0;
        #1;
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_stall", bus.stall, 1'b0);
        chk("midrst_hi_we", bus.hi_we, 1'b0);
        chk("midrst_lo_o", bus.lo_o, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        saw_we = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            saw_we = saw_we | bus.hi_we | bus.lo_we | bus.busy;
        end
        chk("post_rst_quiet", saw_we, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
